// File: rtl/cnn_addr_pkg.sv
// Shared types and helpers for the convolution window address generator.
package cnn_addr_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    // Number of window positions along one image axis.
    function automatic int out_dim(input int img, input int k, input int s);
        return (img - k) / s + 1;
    endfunction

endpackage

// File: rtl/conv_pos_counter.sv
// Nested kx/ky/ox/oy window counters with incremental row/column address registers.
module conv_pos_counter
    import cnn_addr_pkg::*;
#(
    parameter int IMG_W     = 80,
    parameter int IMG_H     = 60,
    parameter int KERNEL    = 3,
    parameter int STRIDE    = 1,
    parameter int BASE_ADDR = 0,
    parameter int ADDR_W    = 13
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              tap_mode,
    input  logic              advance,
    output logic [ADDR_W-1:0] addr,
    output logic              win_first,
    output logic              win_last,
    output logic              last
);

    localparam int OUT_W = out_dim(IMG_W, KERNEL, STRIDE);
    localparam int OUT_H = out_dim(IMG_H, KERNEL, STRIDE);
    localparam int KW    = $clog2(KERNEL + 1);
    localparam int OXW   = $clog2(OUT_W + 1);
    localparam int OYW   = $clog2(OUT_H + 1);

    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0] WIN_STEP = ADDR_W'(STRIDE * IMG_W);
    localparam logic [ADDR_W-1:0] COL_STEP = ADDR_W'(STRIDE);

    logic              mode_q;
    logic [KW-1:0]     kx, ky;
    logic [OXW-1:0]    ox;
    logic [OYW-1:0]    oy;
    logic [ADDR_W-1:0] win_row;   // address of the window's top row, column 0
    logic [ADDR_W-1:0] tap_row;   // win_row advanced by ky image rows
    logic [ADDR_W-1:0] win_col;   // ox*STRIDE

    logic kx_wrap, ky_wrap, ox_wrap, oy_wrap;

    // In anchor mode the tap counters never move, so they count as always wrapped.
    assign kx_wrap = !mode_q || (kx == KW'(KERNEL - 1));
    assign ky_wrap = !mode_q || (ky == KW'(KERNEL - 1));
    assign ox_wrap = (ox == OXW'(OUT_W - 1));
    assign oy_wrap = (oy == OYW'(OUT_H - 1));

    assign last      = kx_wrap && ky_wrap && ox_wrap && oy_wrap;
    assign win_first = !mode_q || (kx == '0 && ky == '0);
    assign win_last  = kx_wrap && ky_wrap;
    assign addr      = tap_row + win_col + ADDR_W'(kx);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours, whatever the statement order.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            mode_q  <= rst_n && tap_mode;
            kx      <= '0;
            ky      <= '0;
            ox      <= '0;
            oy      <= '0;
            win_row <= BASE;
            tap_row <= BASE;
            win_col <= '0;
        end else if (advance) begin
            if (!kx_wrap) begin
                kx <= kx + 1'b1;
            end else begin
                kx <= '0;
                if (!ky_wrap) begin
                    ky      <= ky + 1'b1;
                    tap_row <= tap_row + ROW_STEP;
                end else begin
                    ky <= '0;
                    if (!ox_wrap) begin
                        ox      <= ox + 1'b1;
                        win_col <= win_col + COL_STEP;
                        tap_row <= win_row;
                    end else begin
                        ox      <= '0;
                        win_col <= '0;
                        if (!oy_wrap) begin
                            oy      <= oy + 1'b1;
                            win_row <= win_row + WIN_STEP;
                            tap_row <= win_row + WIN_STEP;
                        end else begin
                            oy      <= '0;
                            win_row <= BASE;
                            tap_row <= BASE;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: rtl/conv_window_addr_gen.sv
// Sweeps a KERNEL x KERNEL window over a row-major image, emitting anchor or tap
// addresses over a valid/ready handshake with window framing flags.
module conv_window_addr_gen
    import cnn_addr_pkg::*;
#(
    parameter int IMG_W     = 80,
    parameter int IMG_H     = 60,
    parameter int KERNEL    = 3,
    parameter int STRIDE    = 1,
    parameter int BASE_ADDR = 0,
    parameter int ADDR_W    = 13
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              tap_mode,
    output logic [ADDR_W-1:0] addr,
    output logic              addr_valid,
    input  logic              addr_ready,
    output logic              win_first,
    output logic              win_last,
    output logic              busy,
    output logic              done
);

    if (KERNEL < 1 || KERNEL > IMG_W || KERNEL > IMG_H) begin : g_bad_kernel
        $error("conv_window_addr_gen: KERNEL out of range");
    end
    if (STRIDE < 1) begin : g_bad_stride
        $error("conv_window_addr_gen: STRIDE must be >= 1");
    end
    if (64'(BASE_ADDR) + 64'(IMG_W) * 64'(IMG_H) - 64'd1 >= (64'd1 << ADDR_W)) begin : g_bad_addr_w
        $error("conv_window_addr_gen: ADDR_W too small for image");
    end

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_addr;
    logic              cnt_first, cnt_last_tap, cnt_last;
    logic              fire, clear;

    assign fire  = addr_valid && addr_ready;
    assign clear = (state_q == IDLE) && start;

    conv_pos_counter #(
        .IMG_W    (IMG_W),
        .IMG_H    (IMG_H),
        .KERNEL   (KERNEL),
        .STRIDE   (STRIDE),
        .BASE_ADDR(BASE_ADDR),
        .ADDR_W   (ADDR_W)
    ) u_pos (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (clear),
        .tap_mode (tap_mode),
        .advance  (fire),
        .addr     (cnt_addr),
        .win_first(cnt_first),
        .win_last (cnt_last_tap),
        .last     (cnt_last)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // NOTE: every output of this block is given a default first, so no path
    // through the case leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        addr_valid = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_q)
            IDLE: if (start) state_d = RUN;
            RUN: begin
                addr_valid = 1'b1;
                busy       = 1'b1;
                if (addr_ready && cnt_last) state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs read as zero whenever no address is on offer.
    assign addr      = addr_valid ? cnt_addr : '0;
    assign win_first = addr_valid && cnt_first;
    assign win_last  = addr_valid && cnt_last_tap;

endmodule

// File: tb/tb_conv_window_addr_gen.sv
// Directed self-checking bench: four parameterisations of the address generator
// share one driver task selected by an instance index.
module tb_conv_window_addr_gen;

    typedef struct {
        logic [12:0] a;
        logic        f;
        logic        l;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        tap_mode = 1'b0;
    logic        addr_ready = 1'b1;
    logic [1:0]  sel = 2'd0;

    logic [12:0] addr_a  [4];
    logic        valid_a [4];
    logic        first_a [4];
    logic        last_a  [4];
    logic        busy_a  [4];
    logic        done_a  [4];

    logic [12:0] m_addr;
    logic        m_valid, m_first, m_last, m_busy, m_done;

    int   checks = 0;
    int   failures = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    conv_window_addr_gen u_def (
        .clk(clk), .rst_n(rst_n), .start(start && sel == 2'd0), .tap_mode(tap_mode),
        .addr(addr_a[0]), .addr_valid(valid_a[0]), .addr_ready(addr_ready),
        .win_first(first_a[0]), .win_last(last_a[0]), .busy(busy_a[0]), .done(done_a[0]));

    conv_window_addr_gen #(.IMG_W(8), .IMG_H(6), .KERNEL(3), .STRIDE(2)) u_s2 (
        .clk(clk), .rst_n(rst_n), .start(start && sel == 2'd1), .tap_mode(tap_mode),
        .addr(addr_a[1]), .addr_valid(valid_a[1]), .addr_ready(addr_ready),
        .win_first(first_a[1]), .win_last(last_a[1]), .busy(busy_a[1]), .done(done_a[1]));

    conv_window_addr_gen #(.IMG_W(5), .IMG_H(5), .KERNEL(3), .STRIDE(1)) u_tap (
        .clk(clk), .rst_n(rst_n), .start(start && sel == 2'd2), .tap_mode(tap_mode),
        .addr(addr_a[2]), .addr_valid(valid_a[2]), .addr_ready(addr_ready),
        .win_first(first_a[2]), .win_last(last_a[2]), .busy(busy_a[2]), .done(done_a[2]));

    conv_window_addr_gen #(.IMG_W(4), .IMG_H(2), .KERNEL(1), .STRIDE(1), .BASE_ADDR(100)) u_base (
        .clk(clk), .rst_n(rst_n), .start(start && sel == 2'd3), .tap_mode(tap_mode),
        .addr(addr_a[3]), .addr_valid(valid_a[3]), .addr_ready(addr_ready),
        .win_first(first_a[3]), .win_last(last_a[3]), .busy(busy_a[3]), .done(done_a[3]));

    always_comb begin
        m_addr  = addr_a[sel];
        m_valid = valid_a[sel];
        m_first = first_a[sel];
        m_last  = last_a[sel];
        m_busy  = busy_a[sel];
        m_done  = done_a[sel];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_addr"}, 32'(m_addr), 0);
        check({tag, "_valid"}, 32'(m_valid), 0);
        check({tag, "_first"}, 32'(m_first), 0);
        check({tag, "_last"}, 32'(m_last), 0);
        check({tag, "_busy"}, 32'(m_busy), 0);
        check({tag, "_done"}, 32'(m_done), 0);
    endtask

    // Runs one sweep on instance sel_i against exp_q. Negative indices disable
    // the stall / mid-sweep start / mid-sweep reset features.
    task automatic run(input logic [1:0] sel_i, input logic tap, input int stall_idx,
                       input int pulse_idx, input int rst_idx);
        int n = 0;
        int stall = 0;
        int cyc = 0;
        sel        = sel_i;
        tap_mode   = tap;
        addr_ready = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        tap_mode = ~tap;   // must not affect the sweep in progress
        while (n < exp_q.size()) begin
            cyc++;
            if (cyc > 20000) begin
                check("timeout", 32'(n), 32'(exp_q.size()));
                return;
            end
            if (n == rst_idx) begin
                rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                check_idle("midrst");
                repeat (3) begin
                    @(negedge clk);
                    check("midrst_nodone", 32'(m_done), 0);
                    check("midrst_nobusy", 32'(m_busy), 0);
                end
                return;
            end
            check("valid", 32'(m_valid), 1);
            check("addr", 32'(m_addr), 32'(exp_q[n].a));
            check("win_first", 32'(m_first), 32'(exp_q[n].f));
            check("win_last", 32'(m_last), 32'(exp_q[n].l));
            start = (n == pulse_idx);
            if (n == stall_idx && stall < 5) begin
                addr_ready = 1'b0;
                stall++;
            end else begin
                addr_ready = 1'b1;
                n++;
            end
            @(negedge clk);
        end
        start = 1'b0;
        addr_ready = 1'b1;
        check("done_pulse", 32'(m_done), 1);
        check("done_valid", 32'(m_valid), 0);
        check("done_busy", 32'(m_busy), 0);
        @(negedge clk);
        check("after_done", 32'(m_done), 0);
        check("after_busy", 32'(m_busy), 0);
    endtask

    task automatic load_default();
        exp_q.delete();
        for (int oy = 0; oy < 58; oy++)
            for (int ox = 0; ox < 78; ox++)
                exp_q.push_back('{a: 13'(oy * 80 + ox), f: 1'b1, l: 1'b1});
    endtask

    initial begin
        logic [12:0] s2_vec [6];
        s2_vec = '{13'd0, 13'd2, 13'd4, 13'd16, 13'd18, 13'd20};

        repeat (2) @(negedge clk);
        check_idle("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_idle("idle");

        // Full default anchor sweep: 4524 addresses ending at 4637.
        load_default();
        check("def_count", 32'(exp_q.size()), 4524);
        check("def_last_addr", 32'(exp_q[exp_q.size()-1].a), 4637);
        run(2'd0, 1'b0, -1, -1, -1);

        // Backpressure on the third address plus an ignored mid-sweep start.
        run(2'd0, 1'b0, 2, 50, -1);

        // Reset after 100 transfers, then a clean restart from BASE_ADDR.
        run(2'd0, 1'b0, -1, -1, 100);
        run(2'd0, 1'b0, -1, -1, -1);

        // 8x6, K=3, S=2 anchor sweep.
        exp_q.delete();
        for (int i = 0; i < 6; i++) exp_q.push_back('{a: s2_vec[i], f: 1'b1, l: 1'b1});
        run(2'd1, 1'b0, -1, -1, -1);

        // 5x5, K=3 tap sweep: 81 taps, first window 0,1,2,5,6,7,10,11,12.
        exp_q.delete();
        for (int oy = 0; oy < 3; oy++)
            for (int ox = 0; ox < 3; ox++)
                for (int ky = 0; ky < 3; ky++)
                    for (int kx = 0; kx < 3; kx++)
                        exp_q.push_back('{a: 13'((oy + ky) * 5 + ox + kx),
                                          f: (kx == 0 && ky == 0),
                                          l: (kx == 2 && ky == 2)});
        run(2'd2, 1'b1, 4, -1, -1);

        // BASE_ADDR=100, K=1, 4x2: addresses 100..107.
        exp_q.delete();
        for (int i = 0; i < 8; i++) exp_q.push_back('{a: 13'(100 + i), f: 1'b1, l: 1'b1});
        run(2'd3, 1'b0, -1, -1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
